// File: rtl/prog_mem_ctrl.sv
// Program memory with a loader write port, a 1-cycle registered fetch port and a
// sequential wipe engine that zeroes one word per cycle.
module prog_mem_ctrl #(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [N-1:0] wr_addr,
    input  logic [M-1:0] wr_data,
    input  logic         rd_req,
    input  logic [N-1:0] rd_addr,
    output logic [M-1:0] rd_data,
    output logic         rd_valid,
    input  logic         wipe,
    output logic         busy,
    output logic         wipe_done
);

    localparam int L = 2 ** N;
    localparam logic [N-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE,
        WIPE,
        DONE
    } state_t;

    state_t         state_reg;
    logic [N-1:0]   wipe_cnt_reg;
    logic [M-1:0]   rd_data_reg;
    logic           rd_valid_reg;
    logic           busy_reg;
    logic           wipe_done_reg;

    logic [M-1:0]   mem [L];

    logic           idle_cmd;
    logic           rd_hit;
    logic           mem_we;
    logic [N-1:0]   mem_waddr;
    logic [M-1:0]   mem_wdata;

    // Loader and fetch commands are only honoured in IDLE when no wipe is requested.
    assign idle_cmd = (state_reg == IDLE) && !wipe;
    assign rd_hit   = wr_en && (wr_addr == rd_addr);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_reg == WIPE) begin
            mem_we    = 1'b1;
            mem_waddr = wipe_cnt_reg;
            mem_wdata = '0;
        end else if (idle_cmd && wr_en) begin
            mem_we = 1'b1;
        end
    end

    // Array has no reset: contents survive clr, including a partially wiped state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg     <= IDLE;
            wipe_cnt_reg  <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            wipe_done_reg <= 1'b0;
        end else begin
            rd_valid_reg  <= 1'b0;
            wipe_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wipe) begin
                        state_reg    <= WIPE;
                        wipe_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                    end else if (rd_req) begin
                        // Write-first: a same-address write bypasses the array.
                        rd_data_reg  <= rd_hit ? wr_data : mem[rd_addr];
                        rd_valid_reg <= 1'b1;
                    end
                end
                WIPE: begin
                    wipe_cnt_reg <= wipe_cnt_reg + 1'b1;
                    if (wipe_cnt_reg == LAST_ADDR) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        wipe_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
    assign busy      = busy_reg;
    assign wipe_done = wipe_done_reg;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Bench for prog_mem_ctrl: scoreboard of expected fetch data plus per-scenario checks,
// with a second instance exercising a wider/deeper configuration.
module tb_prog_mem_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        wr_en, rd_req, wipe;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;
    logic        rd_valid, busy, wipe_done;

    logic        wr_en_b, rd_req_b, wipe_b;
    logic [5:0]  wr_addr_b, rd_addr_b;
    logic [31:0] wr_data_b, rd_data_b;
    logic        rd_valid_b, busy_b, wipe_done_b;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] model [16];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    prog_mem_ctrl #(.N(4), .M(16)) dut (
        .clk(clk), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wipe(wipe), .busy(busy), .wipe_done(wipe_done)
    );

    prog_mem_ctrl #(.N(6), .M(32)) dut_b (
        .clk(clk), .clr(clr),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wipe(wipe_b), .busy(busy_b), .wipe_done(wipe_done_b)
    );

    // Scoreboard monitor: every rd_valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (!clr && rd_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rd_valid: got rd_data=%h with no read outstanding", rd_data);
            end else begin
                logic [15:0] exp_d;
                exp_d = exp_q.pop_front();
                if (rd_data !== exp_d) begin
                    miscompares++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, exp_d);
                end else begin
                    $display("read ok: rd_data=%h", rd_data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model[a] = d;
        tick();
        wr_en = 1'b0;
        $display("write @%0d = %h", a, d);
    endtask

    task automatic read_word(input logic [3:0] a);
        rd_req = 1'b1; rd_addr = a;
        exp_q.push_back(model[a]);
        tick();
        rd_req = 1'b0;
        vectors++;
        if (rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_valid_latency @%0d: got %b expected 1", a, rd_valid);
        end
    endtask

    // Samples busy once per cycle from the first WIPE cycle until it drops.
    task automatic wait_wipe(input bit inject);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (inject && n == 10) begin
                rd_req = 1'b1; rd_addr = 4'd2;
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hABCD;
            end
            tick();
            rd_req = 1'b0; wr_en = 1'b0;
            if (inject && n == 10) begin
                vectors++;
                if (rd_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_read_ignored: got rd_valid=%b expected 0", rd_valid);
                end
            end
            n++;
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL wipe_busy_cycles: got %0d expected 16", n);
        end
        vectors++;
        if (wipe_done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wipe_done_pulse: got wipe_done=%b busy=%b expected 1/0", wipe_done, busy);
        end
        tick();
        vectors++;
        if (wipe_done !== 1'b0) begin
            miscompares++;
            $display("FAIL wipe_done_width: got %b expected 0", wipe_done);
        end
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        $display("wipe complete after %0d busy cycles", n);
    endtask

    task automatic start_wipe();
        wipe = 1'b1;
        tick();
        wipe = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (rd_data !== 16'h0 || rd_valid !== 1'b0 || busy !== 1'b0 || wipe_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rd_data=%h rd_valid=%b busy=%b wipe_done=%b expected 0",
                     rd_data, rd_valid, busy, wipe_done);
        end
        tick();
        clr = 1'b0;
        tick();
        $display("reset released");
    endtask

    task automatic test_load_fetch();
        start_wipe();
        wait_wipe(1'b0);
        write_word(4'd3, 16'hA5A5);
        write_word(4'd15, 16'h1234);
        read_word(4'd3);
        read_word(4'd15);
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL hold_after_read: got rd_valid=%b rd_data=%h expected 0/1234", rd_valid, rd_data);
        end
        read_word(4'd0);
    endtask

    task automatic test_collision();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF;
        rd_req = 1'b1; rd_addr = 4'd7;
        model[7] = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        tick();
        wr_en = 1'b0; rd_req = 1'b0;
        vectors++;
        if (rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_valid: got %b expected 1", rd_valid);
        end
        // Different addresses in one cycle: both happen.
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h0808;
        rd_req = 1'b1; rd_addr = 4'd3;
        exp_q.push_back(model[3]);
        model[8] = 16'h0808;
        tick();
        wr_en = 1'b0; rd_req = 1'b0;
        read_word(4'd7);
        read_word(4'd8);
    endtask

    task automatic test_full_wipe();
        for (int i = 0; i < 16; i++) write_word(4'(i), 16'hFFFF);
        start_wipe();
        wait_wipe(1'b1);
        for (int i = 0; i < 16; i++) read_word(4'(i));
    endtask

    task automatic test_reset_mid_wipe();
        for (int i = 0; i < 16; i++) write_word(4'(i), 16'h5555);
        read_word(4'd9);
        start_wipe();
        for (int i = 0; i < 5; i++) tick();
        #2;
        clr = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0) begin
            miscompares++;
            $display("FAIL async_clr: got busy=%b rd_valid=%b rd_data=%h expected 0/0/0",
                     busy, rd_valid, rd_data);
        end
        tick();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (wipe_done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL aborted_wipe: got wipe_done=%b busy=%b expected 0/0", wipe_done, busy);
            end
        end
        for (int i = 0; i < 5; i++) model[i] = 16'h0000;
        for (int i = 0; i < 16; i++) read_word(4'(i));
    endtask

    task automatic test_wipe_priority();
        wipe = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h7777;
        rd_req = 1'b1; rd_addr = 4'd2;
        tick();
        wipe = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wipe_priority: got rd_valid=%b busy=%b expected 0/1", rd_valid, busy);
        end
        wait_wipe(1'b0);
        read_word(4'd2);
    endtask

    task automatic test_param_sweep();
        int n;
        wipe_b = 1'b1;
        tick();
        wipe_b = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 64 || wipe_done_b !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_wipe: got %0d busy cycles wipe_done=%b expected 64/1", n, wipe_done_b);
        end
        wr_en_b = 1'b1; wr_addr_b = 6'd63; wr_data_b = 32'hDEADBEEF;
        tick();
        tick();
        wr_en_b = 1'b0;
        rd_req_b = 1'b1; rd_addr_b = 6'd63;
        tick();
        rd_req_b = 1'b0;
        vectors++;
        if (rd_valid_b !== 1'b1 || rd_data_b !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL sweep_read63: got valid=%b data=%h expected 1/deadbeef", rd_valid_b, rd_data_b);
        end
        rd_req_b = 1'b1; rd_addr_b = 6'd40;
        tick();
        rd_req_b = 1'b0;
        vectors++;
        if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0) begin
            miscompares++;
            $display("FAIL sweep_read40: got valid=%b data=%h expected 1/00000000", rd_valid_b, rd_data_b);
        end
        $display("sweep: wipe %0d cycles, read back done", n);
    endtask

    initial begin
        clr = 1'b1;
        wr_en = 1'b0; rd_req = 1'b0; wipe = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        wr_en_b = 1'b0; rd_req_b = 1'b0; wipe_b = 1'b0;
        wr_addr_b = '0; rd_addr_b = '0; wr_data_b = '0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;

        test_reset();
        test_load_fetch();
        test_collision();
        test_full_wipe();
        test_reset_mid_wipe();
        test_wipe_priority();
        test_param_sweep();
        tick();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL outstanding_reads: got %0d unanswered expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_mem_ctrl.md
Name: prog_mem_ctrl

Overview:
Parametrised program memory with a loader write port, a registered read/fetch port with a valid flag, and a multi-cycle wipe engine. Sits between the program loader and the instruction fetch stage. Replaces the combinational-read, tri-state memory with a synchronous, handshaked block that has defined behaviour under reset, wipe and read/write collisions.

Parameters:
N, 4, address width; depth L = 2**N words
M, 16, data word width

Ports:
clk  input  1  system clock, all state changes on rising edge
clr  input  1  reset, asynchronous, active-high; resets control state only, not memory contents
wr_en  input  1  loader write strobe
wr_addr  input  N  loader write address
wr_data  input  M  loader write data
rd_req  input  1  fetch read request
rd_addr  input  N  fetch read address
rd_data  output  M  registered read data
rd_valid  output  1  high for one cycle when rd_data carries the response to the previous cycle's rd_req
wipe  input  1  request to zero the whole array
busy  output  1  high while a wipe is in progress
wipe_done  output  1  one-cycle pulse on completion of a wipe

Behaviour:
- Reset (clr=1, async): state=IDLE, wipe counter=0, rd_data=0, rd_valid=0, busy=0, wipe_done=0. Memory array untouched. Reset mid-wipe aborts the wipe. The partially wiped array keeps its state: words 0..k-1 are zero and the rest are unchanged. No wipe_done is generated.
- FSM states: IDLE, WIPE, DONE.
- IDLE:
  - wipe=1 moves to WIPE and clears the counter. In that cycle, wr_en and rd_req are ignored: no write, no rd_valid.
  - Otherwise, wr_en=1 writes wr_data to mem[wr_addr].
  - Otherwise, rd_req=1 registers mem[rd_addr] into rd_data, and rd_valid=1 on the next cycle.
- Read latency is exactly 1 cycle. Back-to-back rd_req gives one response per cycle.
- rd_data holds its last value when rd_valid=0.
- Read/write collision in the same cycle at the same address: write-first. rd_data = wr_data and the memory is updated. At different addresses, both are performed.
- WIPE:
  - busy=1. Each cycle, mem[counter]=0 and counter+1.
  - After writing word L-1, goes to DONE. A wipe takes exactly L cycles in WIPE.
  - wr_en, rd_req and wipe are ignored; rd_valid=0.
- DONE: busy=0, wipe_done=1 for one cycle. rd_req and wr_en are ignored in this cycle. Next state is IDLE.
- Address arithmetic: N-bit unsigned, no wrap beyond L-1. The wipe counter is N+1 bits internally, or uses an explicit terminal compare at L-1.
- Outputs are never Z. There is no output-enable gating; consumers qualify rd_data with rd_valid.
- Memory contents after power-up (no load, no wipe) are undefined. Benches must load or wipe first.

Test Plan:
- Load then fetch: wipe and wait for wipe_done. Write 0xA5A5 @3 and 0x1234 @15. rd_req @3, then @15 on the next cycle -> rd_valid=1 on the next two cycles with rd_data=0xA5A5, then 0x1234. rd_valid=0 afterwards while rd_data stays 0x1234.
- Collision: in one cycle, wr_en @7 with 0xBEEF and rd_req @7 -> next cycle rd_data=0xBEEF, rd_valid=1. A later read @7 also returns 0xBEEF.
- Full wipe:
  - Fill all 16 words with 0xFFFF, then pulse wipe.
  - busy=1 for exactly 16 cycles, then wipe_done=1 for 1 cycle with busy=0.
  - Reads @0..15 all return 0x0000.
  - An rd_req or wr_en issued while busy=1 produces no rd_valid and no memory change.
- Reset mid-wipe: fill all words with 0x5555, start a wipe, assert clr asynchronously after 5 WIPE cycles (between clock edges). busy, rd_valid and rd_data drop to 0 immediately, and no wipe_done follows. After release, words 0..4 read 0x0000 and words 5..15 read 0x5555.
- Wipe priority: in the IDLE cycle where wipe=1, also drive wr_en @2 with 0x7777 and rd_req @2 -> no rd_valid, and after wipe_done, a read @2 returns 0x0000.
- Parameter sweep: N=6, M=32. Wipe takes 64 busy cycles. Write 0xDEADBEEF @63 and read it back -> rd_data=0xDEADBEEF.
